// File: rtl/router_pkg.sv
// Shared router definitions: port count, address width, FSM state enumeration
// and small address helpers used by the control FSM.
package router_pkg;

    localparam int N_PORTS = 3;
    localparam int ADDR_W  = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return int'(a) < N_PORTS;
    endfunction

    // Out-of-range addresses select nothing and read as 0.
    function automatic logic port_bit(input logic [N_PORTS-1:0] v,
                                      input logic [ADDR_W-1:0]  a);
        logic r;
        r = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (int'(a) == p) begin
                r = v[p];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: header decode, payload/parity sequencing,
// FIFO-full stalls and per-port soft reset. Moore outputs from the state register.
module router_fsm
    import router_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               packet_valid,
    input  logic [ADDR_W-1:0]  datain,
    input  logic               fifo_full,
    input  logic [N_PORTS-1:0] fifo_empty,
    input  logic [N_PORTS-1:0] soft_reset,
    input  logic               parity_done,
    input  logic               low_packet_valid,
    output logic               detect_add,
    output logic               lfd_state,
    output logic               ld_state,
    output logic               laf_state,
    output logic               full_state,
    output logic               rst_int_reg,
    output logic               write_enb_reg,
    output logic               busy,
    output logic [ADDR_W-1:0]  addr_q
);

    state_e             state_q;
    state_e             state_d;
    logic [ADDR_W-1:0]  addr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (packet_valid && addr_valid(datain)) begin
                    addr_d  = datain;
                    state_d = port_bit(fifo_empty, datain) ? LOAD_FIRST_DATA
                                                           : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)          state_d = FIFO_FULL_STATE;
                else if (!packet_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)         state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)           state_d = DECODE_ADDRESS;
                else if (low_packet_valid) state_d = LOAD_PARITY;
                else                       state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (port_bit(fifo_empty, addr_q)) state_d = LOAD_FIRST_DATA;
            end
            default:            state_d = DECODE_ADDRESS;
        endcase

        // A timeout on the selected port abandons the packet from any active state.
        if (state_q != DECODE_ADDRESS && port_bit(soft_reset, addr_q)) begin
            state_d = DECODE_ADDRESS;
        end
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                           (state_q == LOAD_PARITY);
    assign busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table, async-reset sequence and a
// randomized run against a behavioural model of the packet protocol.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       packet_valid;
    logic [1:0] datain;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [1:0] addr_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(datain),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .addr_q(addr_q)
    );

    // Strobe vector order: detect, lfd, ld, laf, full, rst_int, wen, busy
    localparam logic [7:0] S_DEC = 8'h80, S_LFD = 8'h41, S_LD  = 8'h22, S_LAF = 8'h13;
    localparam logic [7:0] S_FFS = 8'h09, S_CPE = 8'h05, S_LP  = 8'h03, S_WTE = 8'h01;

    function automatic logic [7:0] strobes();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};
    endfunction

    task automatic check(input string name, input logic [7:0] exp_s, input logic [1:0] exp_a);
        n_checks++;
        if (strobes() !== exp_s || addr_q !== exp_a) begin
            n_fail++;
            $display("FAIL %s: strobes=%b addr=%0d, required strobes=%b addr=%0d",
                     name, strobes(), addr_q, exp_s, exp_a);
        end
    endtask

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp_s;
        logic [1:0] exp_a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic pv, logic [1:0] din, logic ff, logic [2:0] fe,
                                logic [2:0] sr, logic pd, logic lpv,
                                logic [7:0] es, logic [1:0] ea);
        vec_t v;
        v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.exp_s = es; v.exp_a = ea;
        return v;
    endfunction

    task automatic drive(input logic pv, input logic [1:0] din, input logic ff,
                         input logic [2:0] fe, input logic [2:0] sr,
                         input logic pd, input logic lpv);
        packet_valid = pv; datain = din; fifo_full = ff; fifo_empty = fe;
        soft_reset = sr; parity_done = pd; low_packet_valid = lpv;
    endtask

    // Behavioural model: packet phases and the strobes each phase shows.
    typedef enum {M_IDLE, M_HDR, M_PAY, M_STALL, M_RESUME, M_PAR, M_CHK, M_WAIT} mph_e;
    mph_e m_ph;
    int   m_addr;

    function automatic logic [7:0] m_strobes(mph_e p);
        case (p)
            M_IDLE:   return S_DEC;
            M_HDR:    return S_LFD;
            M_PAY:    return S_LD;
            M_STALL:  return S_FFS;
            M_RESUME: return S_LAF;
            M_PAR:    return S_LP;
            M_CHK:    return S_CPE;
            default:  return S_WTE;
        endcase
    endfunction

    task automatic m_step();
        mph_e nx;
        int   a;
        nx = m_ph;
        a  = int'(datain);
        if (m_ph != M_IDLE && soft_reset[m_addr]) begin
            nx = M_IDLE;
        end else begin
            case (m_ph)
                M_IDLE:   if (packet_valid && a < 3) begin
                              m_addr = a;
                              nx = fifo_empty[a] ? M_HDR : M_WAIT;
                          end
                M_HDR:    nx = M_PAY;
                M_PAY:    nx = fifo_full ? M_STALL : (!packet_valid ? M_PAR : M_PAY);
                M_STALL:  nx = fifo_full ? M_STALL : M_RESUME;
                M_RESUME: nx = parity_done ? M_IDLE : (low_packet_valid ? M_PAR : M_PAY);
                M_PAR:    nx = M_CHK;
                M_CHK:    nx = fifo_full ? M_STALL : M_IDLE;
                M_WAIT:   nx = fifo_empty[m_addr] ? M_HDR : M_WAIT;
            endcase
        end
        m_ph = nx;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 3'b111, 0, 0, 0);
        #12;
        check("reset_state", S_DEC, 2'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("after_reset", S_DEC, 2'd0);

        // clean packet to port 1
        vecs.push_back(mk(1, 1, 0, 3'b111, 0, 0, 0, S_LFD, 1));
        vecs.push_back(mk(1, 1, 0, 3'b111, 0, 0, 0, S_LD,  1));
        vecs.push_back(mk(1, 1, 0, 3'b111, 0, 0, 0, S_LD,  1));
        vecs.push_back(mk(1, 1, 0, 3'b111, 0, 0, 0, S_LD,  1));
        vecs.push_back(mk(0, 0, 0, 3'b111, 0, 0, 0, S_LP,  1));
        vecs.push_back(mk(0, 0, 0, 3'b111, 0, 0, 0, S_CPE, 1));
        vecs.push_back(mk(0, 0, 0, 3'b111, 0, 0, 0, S_DEC, 1));
        // busy destination port 2
        vecs.push_back(mk(1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2));
        vecs.push_back(mk(1, 2, 0, 3'b111, 0, 0, 0, S_LFD, 2));
        vecs.push_back(mk(1, 2, 0, 3'b111, 0, 0, 0, S_LD,  2));
        // full mid-payload
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 2, 1, 3'b111, 0, 0, 0, S_FFS, 2));
        vecs.push_back(mk(1, 2, 0, 3'b111, 0, 0, 0, S_LAF, 2));
        vecs.push_back(mk(1, 2, 0, 3'b111, 0, 0, 0, S_LD,  2));
        // full at end of packet
        vecs.push_back(mk(1, 2, 1, 3'b111, 0, 0, 0, S_FFS, 2));
        vecs.push_back(mk(0, 2, 0, 3'b111, 0, 0, 0, S_LAF, 2));
        vecs.push_back(mk(0, 2, 0, 3'b111, 0, 0, 1, S_LP,  2));
        vecs.push_back(mk(0, 2, 0, 3'b111, 0, 0, 1, S_CPE, 2));
        vecs.push_back(mk(0, 2, 1, 3'b111, 0, 0, 1, S_FFS, 2));
        vecs.push_back(mk(0, 2, 0, 3'b111, 0, 0, 1, S_LAF, 2));
        vecs.push_back(mk(0, 2, 0, 3'b111, 0, 1, 1, S_DEC, 2));
        // invalid address dropped, addr_q held
        vecs.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DEC, 2));
        vecs.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DEC, 2));
        // soft reset: other port ignored, selected port aborts
        vecs.push_back(mk(1, 1, 0, 3'b111, 0, 0, 0, S_LFD, 1));
        vecs.push_back(mk(1, 1, 0, 3'b111, 0, 0, 0, S_LD,  1));
        vecs.push_back(mk(1, 1, 0, 3'b111, 3'b001, 0, 0, S_LD, 1));
        vecs.push_back(mk(1, 1, 0, 3'b111, 3'b010, 0, 0, S_DEC, 1));
        vecs.push_back(mk(0, 1, 0, 3'b111, 0, 0, 0, S_DEC, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].din, vecs[i].ff, vecs[i].fe,
                  vecs[i].sr, vecs[i].pd, vecs[i].lpv);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_a);
        end

        // asynchronous reset while stalled
        drive(1, 0, 0, 3'b111, 0, 0, 0);
        @(posedge clk); #1; check("ar_lfd", S_LFD, 0);
        @(posedge clk); #1; check("ar_ld", S_LD, 0);
        fifo_full = 1'b1;
        @(posedge clk); #1; check("ar_ffs", S_FFS, 0);
        drive(1, 1, 0, 3'b111, 0, 0, 0);
        @(posedge clk); #1; check("ar_laf", S_LAF, 0);
        fifo_full = 1'b1;
        @(posedge clk); #1; check("ar_ld2", S_LD, 0);
        @(posedge clk); #1; check("ar_ffs2", S_FFS, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_midcycle", S_DEC, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 0, 3'b111, 0, 0, 0);
        @(posedge clk); #1;
        check("post_async_reset", S_DEC, 0);

        // randomized run against the model
        m_ph   = M_IDLE;
        m_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset = 1'b1;
                #1;
                m_ph = M_IDLE; m_addr = 0;
                check("rand_reset", m_strobes(m_ph), 2'(m_addr));
                @(posedge clk); #1;
                reset = 1'b0;
            end
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 29) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            m_step();
            @(posedge clk); #1;
            check($sformatf("rand%0d", c), m_strobes(m_ph), 2'(m_addr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
